// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP32 multiplier among NUM_REQ requesters.
// Define FPU_MUL_ARB_TIMEOUT_EN to add the BUSY hang watchdog (timeout_err, HALT state).
module fpu_mul_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [31:0]           resp_data,
    output logic [ID_W-1:0]       resp_id,
    output logic                  busy,
    output logic [31:0]           mul_din1,
    output logic [31:0]           mul_din2,
    output logic                  mul_valid,
    input  logic [31:0]           mul_result,
    input  logic                  mul_ready,
    output logic                  timeout_err
);

    localparam int SCAN_W = ID_W + 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("fpu_mul_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

`ifdef FPU_MUL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_BUSY    = 3'd2,
        S_RESPOND = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    logic [CNT_W-1:0] r_busy_cnt;
    logic             r_timeout_err;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_BUSY    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;
`endif

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_grant;
    logic [NUM_REQ-1:0] r_req_ack;
    logic [NUM_REQ-1:0] r_resp_valid;
    logic [31:0]       r_resp_data;
    logic [ID_W-1:0]   r_resp_id;
    logic [31:0]       r_mul_din1;
    logic [31:0]       r_mul_din2;
    logic              r_mul_valid;

    logic              w_grant_found;
    logic [ID_W-1:0]   w_grant_idx;
    logic [ID_W-1:0]   w_next_ptr;
    logic [SCAN_W-1:0] w_scan;

    // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + SCAN_W'(k);
            if (w_scan >= SCAN_W'(NUM_REQ)) begin
                w_scan = w_scan - SCAN_W'(NUM_REQ);
            end
            if (!w_grant_found && req_valid[w_scan[ID_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan[ID_W-1:0];
            end
        end
    end

    assign w_next_ptr = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

    // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_req_ack    <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
            r_mul_din1   <= '0;
            r_mul_din2   <= '0;
            r_mul_valid  <= 1'b0;
`ifdef FPU_MUL_ARB_TIMEOUT_EN
            r_busy_cnt    <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle; only the transitions below raise them.
            r_req_ack    <= '0;
            r_resp_valid <= '0;
            r_mul_valid  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_grant_found) begin
                        r_mul_din1  <= req_a[32*w_grant_idx +: 32];
                        r_mul_din2  <= req_b[32*w_grant_idx +: 32];
                        r_grant     <= w_grant_idx;
                        r_rr_ptr    <= w_next_ptr;
                        r_req_ack   <= ONE_HOT0 << w_grant_idx;
                        r_mul_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
`ifdef FPU_MUL_ARB_TIMEOUT_EN
                    r_busy_cnt <= '0;
`endif
                    r_state    <= S_BUSY;
                end

                S_BUSY: begin
                    if (mul_ready) begin
                        r_resp_data  <= mul_result;
                        r_resp_valid <= ONE_HOT0 << r_grant;
                        r_resp_id    <= r_grant;
                        r_state      <= S_RESPOND;
`ifdef FPU_MUL_ARB_TIMEOUT_EN
                    end else if (r_busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_resp_data   <= QNAN;
                        r_resp_valid  <= ONE_HOT0 << r_grant;
                        r_resp_id     <= r_grant;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_RESPOND;
                    end else begin
                        r_busy_cnt <= r_busy_cnt + 1'b1;
`endif
                    end
                end

                S_RESPOND: begin
`ifdef FPU_MUL_ARB_TIMEOUT_EN
                    r_state <= r_timeout_err ? S_HALT : S_IDLE;
`else
                    r_state <= S_IDLE;
`endif
                end

`ifdef FPU_MUL_ARB_TIMEOUT_EN
                // A hung multiplier parks the arbiter until reset.
                S_HALT: r_state <= S_HALT;
`endif

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ack    = r_req_ack;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_id    = r_resp_id;
    assign busy       = (r_state != S_IDLE);
    assign mul_din1   = r_mul_din1;
    assign mul_din2   = r_mul_din2;
    assign mul_valid  = r_mul_valid;

`ifdef FPU_MUL_ARB_TIMEOUT_EN
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Scoreboard bench for fpu_mul_arbiter with a latency-programmable multiplier stub.
// Build with FPU_MUL_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=8).
module tb_fpu_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TO_CYC  = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ack;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [31:0]           resp_data;
    logic [ID_W-1:0]       resp_id;
    logic                  busy;
    logic [31:0]           mul_din1;
    logic [31:0]           mul_din2;
    logic                  mul_valid;
    logic [31:0]           mul_result;
    logic                  mul_ready;
    logic                  timeout_err;

    logic                  stub_ready;
    logic [31:0]           stub_result;
    logic                  stray_ready;
    int                    stub_lat;
    int                    s_cnt;
    logic [31:0]           s_res;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
    } exp_t;

    exp_t sb_q[$];
    int   grant_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   n_acks    = 0;
    int   n_resps   = 0;
    int   ack_cyc   = 0;
    int   resp_cyc  = 0;
    bit   auto_drop = 1'b1;

    fpu_mul_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ack     (req_ack),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_id     (resp_id),
        .busy        (busy),
        .mul_din1    (mul_din1),
        .mul_din2    (mul_din2),
        .mul_valid   (mul_valid),
        .mul_result  (mul_result),
        .mul_ready   (mul_ready),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Truncating FP32 multiply, adequate for the normal operands used here.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (m[47]) begin
            m = m >> 1;
            e = e + 10'd1;
        end
        return {a[31] ^ b[31], e[7:0], m[45:23]};
    endfunction

    // Multiplier stub: ready pulses stub_lat cycles after the mul_valid cycle; 0 means never.
    always @(posedge clk) begin
        stub_ready <= 1'b0;
        if (reset) begin
            s_cnt       <= 0;
            stub_result <= '0;
        end else if (mul_valid) begin
            if (stub_lat == 1) begin
                stub_ready  <= 1'b1;
                stub_result <= fp_mul(mul_din1, mul_din2);
                s_cnt       <= 0;
            end else if (stub_lat > 1) begin
                s_cnt <= stub_lat - 1;
                s_res <= fp_mul(mul_din1, mul_din2);
            end else begin
                s_cnt <= 0;
            end
        end else if (s_cnt != 0) begin
            s_cnt <= s_cnt - 1;
            if (s_cnt == 1) begin
                stub_ready  <= 1'b1;
                stub_result <= s_res;
            end
        end
    end

    assign mul_ready  = stub_ready | stray_ready;
    assign mul_result = stray_ready ? 32'hDEAD_BEEF : stub_result;

    // Advance one cycle; sample at the falling edge and retire scoreboard entries.
    task automatic tick();
        exp_t e;
        int   g;
        @(negedge clk);
        cyc++;
        if (req_ack != '0 && resp_valid != '0) begin
            n_errors++;
            $display("FAIL ack_resp_overlap: req_ack=%b resp_valid=%b, required never together", req_ack, resp_valid);
        end
        if (req_ack != '0) begin
            n_checks++;
            n_acks++;
            ack_cyc = cyc;
            if (grant_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_ack: req_ack=%b, required none", req_ack);
            end else begin
                g = grant_q.pop_front();
                if (req_ack !== (NUM_REQ'(1) << g)) begin
                    n_errors++;
                    $display("FAIL grant_order: req_ack=%b, required one-hot bit %0d", req_ack, g);
                end
            end
            if (auto_drop) req_valid = req_valid & ~req_ack;
        end
        if (resp_valid != '0) begin
            n_checks++;
            n_resps++;
            resp_cyc = cyc;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_resp: resp_valid=%b data=%h, required none", resp_valid, resp_data);
            end else begin
                e = sb_q.pop_front();
                if (resp_valid !== (NUM_REQ'(1) << e.id) || resp_id !== e.id || resp_data !== e.data) begin
                    n_errors++;
                    $display("FAIL response: valid=%b id=%0d data=%h, required id=%0d data=%h",
                             resp_valid, resp_id, resp_data, e.id, e.data);
                end
            end
        end
    endtask

    task automatic expect_op(input int g, input logic [31:0] d);
        exp_t e;
        e.id   = ID_W'(g);
        e.data = d;
        grant_q.push_back(g);
        sb_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic drain(input int budget, input string name);
        for (int c = 0; c < budget && (grant_q.size() != 0 || sb_q.size() != 0); c++) tick();
        n_checks++;
        if (grant_q.size() != 0 || sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_%s: %0d grants and %0d responses outstanding, required 0",
                     name, grant_q.size(), sb_q.size());
            grant_q.delete();
            sb_q.delete();
        end
    endtask

    task automatic apply_reset();
        req_valid = '0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] op_a(input int i);
        return 32'h3F80_0000 | (32'(i) << 20);
    endfunction

    function automatic logic [31:0] op_b(input int i);
        return 32'h4000_0000 | (32'(i + 1) << 19);
    endfunction

    task automatic test_reset();
        tick();
        tick();
        n_checks++; if (req_ack !== '0)     begin n_errors++; $display("FAIL rst_req_ack: %b, required 0", req_ack); end
        n_checks++; if (resp_valid !== '0)  begin n_errors++; $display("FAIL rst_resp_valid: %b, required 0", resp_valid); end
        n_checks++; if (resp_data !== '0)   begin n_errors++; $display("FAIL rst_resp_data: %h, required 0", resp_data); end
        n_checks++; if (busy !== 1'b0)      begin n_errors++; $display("FAIL rst_busy: %b, required 0", busy); end
        n_checks++; if (mul_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mul_valid: %b, required 0", mul_valid); end
        n_checks++;
        if ({mul_din1, mul_din2, resp_id, timeout_err} !== '0) begin
            n_errors++;
            $display("FAIL rst_misc: din1=%h din2=%h id=%0d terr=%b, required all 0", mul_din1, mul_din2, resp_id, timeout_err);
        end
        reset = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy: %b, required 0", busy); end
    endtask

    task automatic test_single();
        bit seen = 1'b0;
        stub_lat = 3;
        expect_op(0, 32'h40C0_0000);
        set_req(0, 32'h4000_0000, 32'h4040_0000);
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (req_ack != '0) begin
                seen = 1'b1;
                n_checks++;
                if (mul_valid !== 1'b1 || mul_din1 !== 32'h4000_0000 || mul_din2 !== 32'h4040_0000 || busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL issue: valid=%b din1=%h din2=%h busy=%b, required 1 40000000 40400000 1",
                             mul_valid, mul_din1, mul_din2, busy);
                end
            end
        end
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL issue_timeout: no req_ack within 10 cycles, required one"); end
        req_a[31:0] = 32'h1234_5678;
        tick();
        n_checks++;
        if (mul_valid !== 1'b0 || mul_din1 !== 32'h4000_0000 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_hold: valid=%b din1=%h busy=%b, required 0 40000000 1", mul_valid, mul_din1, busy);
        end
        drain(30, "single");
        n_checks++;
        if (resp_cyc - ack_cyc != 4) begin
            n_errors++;
            $display("FAIL latency_l3: ack-to-resp %0d cycles, required 4", resp_cyc - ack_cyc);
        end
    endtask

    task automatic test_fairness();
        int start;
        int order[6] = '{0, 1, 2, 3, 0, 1};
        apply_reset();
        stub_lat  = 2;
        auto_drop = 1'b0;
        foreach (order[k]) expect_op(order[k], fp_mul(op_a(order[k]), op_b(order[k])));
        start = n_acks;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, op_a(i), op_b(i));
        for (int c = 0; c < 200 && n_acks - start < 6; c++) tick();
        req_valid = '0;
        auto_drop = 1'b1;
        drain(60, "fairness");
    endtask

    task automatic test_wrap_sign();
        apply_reset();
        stub_lat = 2;
        expect_op(2, 32'hC040_0000);
        set_req(2, 32'h3FC0_0000, 32'hC000_0000);
        drain(30, "sign");
        expect_op(3, fp_mul(op_a(3), op_b(3)));
        expect_op(1, fp_mul(op_a(1), op_b(1)));
        set_req(1, op_a(1), op_b(1));
        set_req(3, op_a(3), op_b(3));
        drain(60, "wrap");
    endtask

    task automatic test_stray_ready();
        int          r0;
        logic [31:0] held;
        tick();
        tick();
        held = resp_data;
        r0   = n_resps;
        stray_ready = 1'b1;
        tick();
        stray_ready = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        n_checks++;
        if (n_resps != r0 || resp_data !== held || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL stray_ready: resps=%0d data=%h busy=%b, required %0d %h 0", n_resps - r0, resp_data, busy, 0, held);
        end
        stub_lat = 1;
        expect_op(1, fp_mul(op_a(1), op_b(2)));
        set_req(1, op_a(1), op_b(2));
        drain(30, "early_ready");
        n_checks++;
        if (resp_cyc - ack_cyc != 2) begin
            n_errors++;
            $display("FAIL latency_l1: ack-to-resp %0d cycles, required 2", resp_cyc - ack_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        int first_ack = 0;
        stub_lat = 1;
        expect_op(2, fp_mul(op_a(2), op_b(0)));
        expect_op(0, fp_mul(op_a(0), op_b(2)));
        start = n_acks;
        set_req(0, op_a(0), op_b(2));
        set_req(2, op_a(2), op_b(0));
        for (int c = 0; c < 30 && n_acks - start < 2; c++) begin
            tick();
            if (n_acks - start == 1 && first_ack == 0) first_ack = ack_cyc;
        end
        n_checks++;
        if (ack_cyc - first_ack != 4) begin
            n_errors++;
            $display("FAIL back_to_back: ack spacing %0d cycles, required 4", ack_cyc - first_ack);
        end
        drain(30, "b2b");
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        stub_lat = 0;
        grant_q.push_back(1);
        set_req(1, op_a(1), op_b(1));
        for (int c = 0; c < 10 && grant_q.size() != 0; c++) tick();
        for (int c = 0; c < 3; c++) tick();
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL pre_reset_busy: %b, required 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({req_ack, resp_valid, resp_data, resp_id, busy, mul_valid, mul_din1, mul_din2, timeout_err} !== '0) begin
            n_errors++;
            $display("FAIL mid_reset: ack=%b rv=%b data=%h busy=%b mv=%b din1=%h, required all 0",
                     req_ack, resp_valid, resp_data, busy, mul_valid, mul_din1);
        end
        stub_lat = 2;
        expect_op(0, fp_mul(op_a(0), op_b(3)));
        expect_op(2, fp_mul(op_a(2), op_b(3)));
        set_req(2, op_a(2), op_b(3));
        set_req(0, op_a(0), op_b(3));
        drain(60, "after_reset");
    endtask

`ifdef FPU_MUL_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int a0;
        apply_reset();
        stub_lat = 0;
        expect_op(3, 32'h7FC0_0000);
        set_req(3, op_a(3), op_b(3));
        drain(40, "timeout");
        n_checks++;
        if (resp_cyc - ack_cyc != TO_CYC + 1) begin
            n_errors++;
            $display("FAIL timeout_latency: ack-to-resp %0d cycles, required %0d", resp_cyc - ack_cyc, TO_CYC + 1);
        end
        n_checks++;
        if (timeout_err !== 1'b1) begin n_errors++; $display("FAIL timeout_flag: %b, required 1", timeout_err); end
        a0 = n_acks;
        set_req(0, op_a(0), op_b(0));
        for (int c = 0; c < 20; c++) tick();
        n_checks++;
        if (n_acks != a0 || busy !== 1'b1 || timeout_err !== 1'b1) begin
            n_errors++;
            $display("FAIL halt: acks=%0d busy=%b terr=%b, required 0 1 1", n_acks - a0, busy, timeout_err);
        end
        apply_reset();
        n_checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_reset: terr=%b busy=%b, required 0 0", timeout_err, busy);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        stray_ready = 1'b0;
        stub_lat    = 1;
        test_reset();
        test_single();
        test_fairness();
        test_wrap_sign();
        test_stray_ready();
        test_back_to_back();
        test_reset_mid_busy();
`ifdef FPU_MUL_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
